stim_current_gen: RTL
=====================

Name: stim_current_gen

Overview:
- Synthesizable multi-channel input-current stimulus generator that drives the i_in current of each neuron channel in the SNN core.
- Generalises the fixed single-value current stimulus to NCH independent channels.
- Each channel has its own amplitude, onset delay and waveform mode: off, step, pulse train or ramp.
- Timebase is the neuron computation step (COMP_CYCLE clocks), so stimulus edges align with neuron updates.

Parameters:
- NCH, 4, number of neuron channels
- WORD, 18, current word width, signed two's complement fixed point
- CNT_W, 16, width of delay/on/off step counters; must be <= WORD
- COMP_CYCLE, 1000, clocks per neuron computation step
- NOISE_BITS, 6, noise magnitude width (used only with STIM_NOISE_EN)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  run stimulus; low = stopped
- cfg_we  in  1  configuration write strobe
- cfg_ch  in  $clog2(NCH)  target channel
- cfg_addr  in  2  0=amplitude, 1=delay steps, 2=on steps, 3={off steps[CNT_W-1:0], mode[1:0] in cfg_data[WORD-1:WORD-2]}
- cfg_data  in  WORD  write data; counter fields use low CNT_W bits
- i_out  out  NCH*WORD  per-channel current, channel k at [k*WORD +: WORD]
- step_tick  out  1  one-cycle pulse at each computation-step boundary
- active  out  NCH  channel is in ON or OFF phase (past delay)

Behaviour:
- Reset: all config registers 0 (mode off), prescaler 0, all channels IDLE, i_out=0, step_tick=0, active=0, enable_d=0.
- Prescaler:
  - Counts 0..COMP_CYCLE-1 while enable=1.
  - step_tick=1 for the cycle in which count==COMP_CYCLE-1.
  - enable=0 clears the prescaler to 0.
- Channel FSM states: IDLE, DELAY, ON, OFF.
- enable=0: every channel is forced to IDLE with its output 0; config registers are retained.
- Start (enable=1 and enable_d=0): channels with mode!=0 go to DELAY and load dly_cnt=delay; mode=0 channels stay IDLE.
- DELAY, on step_tick:
  - dly_cnt==0: go to ON, load on_cnt.
  - Otherwise decrement dly_cnt.
  - First nonzero output is registered on the tick edge, i.e. (delay+1)*COMP_CYCLE clocks after the start cycle.
- ON output by mode:
  - Mode 1 (step): output=amplitude; stays in ON forever.
  - Mode 2 (pulse): output=amplitude for max(on,1) ticks, then OFF with output 0 for off ticks, then back to ON. off=0 means output stays on continuously.
  - Mode 3 (ramp): output starts at amplitude on ON entry and adds amplitude on each later tick. Saturate at +2^(WORD-1)-1 or -2^(WORD-1); never wrap.
- active=1 in ON or OFF.
- Amplitude write while ON: new value used from the next step_tick. Ramp continues from its current value.
- Write to cfg_addr 3 (mode) while enable=1: that channel restarts in DELAY with the current delay value (IDLE if new mode=0).
- Write and step_tick on the same channel in the same cycle: the write wins and that channel ignores the tick.
- cfg_ch>=NCH: write ignored.
- reset asserted mid-run: everything returns to reset values on the next edge; reset overrides enable and cfg_we.

Optional Feature:
- Macro: STIM_NOISE_EN.
- Defined:
  - Each channel has a 16-bit Galois LFSR (taps 16,14,13,11), seed 16'hACE1 XOR channel index, advanced once per step_tick.
  - While ON, output = base + sign-extended signed LFSR[NOISE_BITS-1:0], saturated as in ramp mode.
  - OFF and IDLE outputs remain exactly 0.
  - LFSRs reset to their seeds on reset.
- Undefined: no LFSR logic; output equals base exactly.

Test Plan:
- Step mode: COMP_CYCLE=10, ch0 mode1, amp=18'h0800, delay=2; raise enable at cycle T.
  - Expect ch0 i_out=0 until T+30, then 18'h0800 held.
  - Other channels stay 0; active[0]=1 from T+30.
- Pulse mode: ch1 mode2, amp=18'h0400, delay=0, on=3, off=2.
  - Expect output 18'h0400 for 30 clocks, then 0 for 20 clocks, repeating; active[1] stays 1.
- Ramp saturation: ch2 mode3, amp=18'h10000.
  - Expect outputs 18'h10000, 18'h1FFFF (saturated), then 18'h1FFFF held; no wrap to negative.
- Negative ramp saturation: mode3, amp=18'h30000.
  - Expect 18'h30000, then 18'h20000 held.
- Mid-run control:
  - Mode write on ch0 in the same cycle as step_tick: channel restarts in DELAY and the tick is ignored.
  - Deassert enable mid-pulse: all i_out=0 next cycle.
  - Re-enable: delays restart from programmed values.
- Reset mid-run: assert reset for 1 cycle while channels are ON.
  - Expect all outputs, active and step_tick = 0 next cycle and config cleared; with enable still high no output until reprogrammed.

Source files
------------

// File: rtl/stim_current_gen.sv
// Multi-channel neuron input-current stimulus: off/step/pulse/ramp per channel.
// Optional STIM_NOISE_EN adds per-channel LFSR noise while a channel is ON.
module stim_current_gen #(
  parameter int NCH        = 4,
  parameter int WORD       = 18,
  parameter int CNT_W      = 16,
  parameter int COMP_CYCLE = 1000,
  parameter int NOISE_BITS = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     cfg_we,
  input  logic [$clog2(NCH)-1:0]   cfg_ch,
  input  logic [1:0]               cfg_addr,
  input  logic [WORD-1:0]          cfg_data,
  output logic [NCH*WORD-1:0]      i_out,
  output logic                     step_tick,
  output logic [NCH-1:0]           active
);

  localparam int PW = (COMP_CYCLE > 1) ? $clog2(COMP_CYCLE) : 1;

  typedef enum logic [1:0] {
    S_IDLE, S_DELAY, S_ON, S_OFF
  } st_t;

  if (CNT_W > WORD || NOISE_BITS < 1 || NOISE_BITS > 16) begin : g_bad_cfg
    $error("stim_current_gen: illegal parameter set");
  end

  logic [PW-1:0]    pre_q;
  logic             en_q;
  logic [WORD-1:0]  amp_q  [NCH];
  logic [CNT_W-1:0] dly_q  [NCH];
  logic [CNT_W-1:0] on_q   [NCH];
  logic [CNT_W-1:0] off_q  [NCH];
  logic [1:0]       mode_q [NCH];

  st_t              st_q   [NCH];
  st_t              st_d   [NCH];
  logic [CNT_W-1:0] dcnt_q [NCH];
  logic [CNT_W-1:0] dcnt_d [NCH];
  logic [CNT_W-1:0] ocnt_q [NCH];
  logic [CNT_W-1:0] ocnt_d [NCH];
  logic [CNT_W-1:0] fcnt_q [NCH];
  logic [CNT_W-1:0] fcnt_d [NCH];
  logic [WORD-1:0]  out_q  [NCH];
  logic [WORD-1:0]  out_d  [NCH];

  logic [NCH-1:0]   wr_hit;
  logic             start;

  function automatic logic [WORD-1:0] sat_add(
    input logic [WORD-1:0] a,
    input logic [WORD-1:0] b
  );
    logic [WORD:0] s;
    s = {a[WORD-1], a} + {b[WORD-1], b};
    if (s[WORD] != s[WORD-1])
      return s[WORD] ? {1'b1, {(WORD-1){1'b0}}}
                     : {1'b0, {(WORD-1){1'b1}}};
    return s[WORD-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] on_load(
    input logic [CNT_W-1:0] n
  );
    return (n == '0) ? '0 : n - 1'b1;
  endfunction

  assign step_tick = enable && (pre_q == PW'(COMP_CYCLE - 1));
  assign start     = enable && !en_q;

  always_comb begin
    for (int k = 0; k < NCH; k++)
      wr_hit[k] = cfg_we && (int'(cfg_ch) == k);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q <= '0;
      en_q  <= 1'b0;
    end else begin
      en_q <= enable;
      if (!enable || step_tick) pre_q <= '0;
      else                      pre_q <= pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NCH; k++) begin
        amp_q[k]  <= '0;
        dly_q[k]  <= '0;
        on_q[k]   <= '0;
        off_q[k]  <= '0;
        mode_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (wr_hit[k]) begin
          unique case (cfg_addr)
            2'd0: amp_q[k] <= cfg_data;
            2'd1: dly_q[k] <= cfg_data[CNT_W-1:0];
            2'd2: on_q[k]  <= cfg_data[CNT_W-1:0];
            2'd3: begin
              off_q[k]  <= cfg_data[CNT_W-1:0];
              mode_q[k] <= cfg_data[WORD-1:WORD-2];
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NCH; k++) begin
        st_q[k]   <= S_IDLE;
        dcnt_q[k] <= '0;
        ocnt_q[k] <= '0;
        fcnt_q[k] <= '0;
        out_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        st_q[k]   <= st_d[k];
        dcnt_q[k] <= dcnt_d[k];
        ocnt_q[k] <= ocnt_d[k];
        fcnt_q[k] <= fcnt_d[k];
        out_q[k]  <= out_d[k];
      end
    end
  end

  // A write to a channel masks that channel's tick in the same cycle.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      st_d[k]   = st_q[k];
      dcnt_d[k] = dcnt_q[k];
      ocnt_d[k] = ocnt_q[k];
      fcnt_d[k] = fcnt_q[k];
      out_d[k]  = out_q[k];
      if (!enable) begin
        st_d[k]  = S_IDLE;
        out_d[k] = '0;
      end else if (wr_hit[k] && cfg_addr == 2'd3) begin
        st_d[k]   = (cfg_data[WORD-1:WORD-2] == 2'd0) ? S_IDLE : S_DELAY;
        dcnt_d[k] = dly_q[k];
        out_d[k]  = '0;
      end else if (start) begin
        st_d[k]   = (mode_q[k] == 2'd0) ? S_IDLE : S_DELAY;
        dcnt_d[k] = dly_q[k];
        out_d[k]  = '0;
      end else if (step_tick && !wr_hit[k]) begin
        unique case (st_q[k])
          S_DELAY: begin
            if (dcnt_q[k] == '0) begin
              st_d[k]   = S_ON;
              out_d[k]  = amp_q[k];
              ocnt_d[k] = on_load(on_q[k]);
            end else begin
              dcnt_d[k] = dcnt_q[k] - 1'b1;
            end
          end
          S_ON: begin
            unique case (mode_q[k])
              2'd1: out_d[k] = amp_q[k];
              2'd2: begin
                if (ocnt_q[k] != '0) begin
                  ocnt_d[k] = ocnt_q[k] - 1'b1;
                  out_d[k]  = amp_q[k];
                end else if (off_q[k] == '0) begin
                  ocnt_d[k] = on_load(on_q[k]);
                  out_d[k]  = amp_q[k];
                end else begin
                  st_d[k]   = S_OFF;
                  fcnt_d[k] = off_q[k] - 1'b1;
                  out_d[k]  = '0;
                end
              end
              2'd3: out_d[k] = sat_add(out_q[k], amp_q[k]);
              default: begin
                st_d[k]  = S_IDLE;
                out_d[k] = '0;
              end
            endcase
          end
          S_OFF: begin
            if (fcnt_q[k] == '0) begin
              st_d[k]   = S_ON;
              out_d[k]  = amp_q[k];
              ocnt_d[k] = on_load(on_q[k]);
            end else begin
              fcnt_d[k] = fcnt_q[k] - 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef STIM_NOISE_EN
  logic [15:0] lfsr_q [NCH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NCH; k++)
        lfsr_q[k] <= 16'hACE1 ^ 16'(k);
    end else if (step_tick) begin
      for (int k = 0; k < NCH; k++)
        lfsr_q[k] <= {1'b0, lfsr_q[k][15:1]}
                   ^ (lfsr_q[k][0] ? 16'hB400 : 16'h0000);
    end
  end

  always_comb begin
    i_out  = '0;
    active = '0;
    for (int k = 0; k < NCH; k++) begin
      active[k] = (st_q[k] == S_ON) || (st_q[k] == S_OFF);
      if (st_q[k] == S_ON)
        i_out[k*WORD +: WORD] = sat_add(out_q[k],
          {{(WORD-NOISE_BITS){lfsr_q[k][NOISE_BITS-1]}},
           lfsr_q[k][NOISE_BITS-1:0]});
    end
  end
`else
  always_comb begin
    i_out  = '0;
    active = '0;
    for (int k = 0; k < NCH; k++) begin
      active[k]             = (st_q[k] == S_ON) || (st_q[k] == S_OFF);
      i_out[k*WORD +: WORD] = out_q[k];
    end
  end
`endif

endmodule
